// File: rtl/kbd_pkg.sv
// Shared constants, state encodings and the optional scancode-to-ASCII table.
// The table is only built when KBD_ASCII_EN is defined.
package kbd_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        D_MAKE,
        D_BREAK,
        D_EXT,
        D_EXT_BREAK
    } dec_state_t;

`ifdef KBD_ASCII_EN
    // Returns {mapped, ascii}; mapped=0 means the key is dropped.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] sc);
        logic [8:0] r;
        r = 9'h000;
        case (sc)
            8'h1C: r = 9'h141;
            8'h32: r = 9'h142;
            8'h21: r = 9'h143;
            8'h23: r = 9'h144;
            8'h24: r = 9'h145;
            8'h2B: r = 9'h146;
            8'h34: r = 9'h147;
            8'h33: r = 9'h148;
            8'h43: r = 9'h149;
            8'h3B: r = 9'h14A;
            8'h42: r = 9'h14B;
            8'h4B: r = 9'h14C;
            8'h3A: r = 9'h14D;
            8'h31: r = 9'h14E;
            8'h44: r = 9'h14F;
            8'h4D: r = 9'h150;
            8'h15: r = 9'h151;
            8'h2D: r = 9'h152;
            8'h1B: r = 9'h153;
            8'h2C: r = 9'h154;
            8'h3C: r = 9'h155;
            8'h2A: r = 9'h156;
            8'h1D: r = 9'h157;
            8'h22: r = 9'h158;
            8'h35: r = 9'h159;
            8'h1A: r = 9'h15A;
            8'h45: r = 9'h130;
            8'h16: r = 9'h131;
            8'h1E: r = 9'h132;
            8'h26: r = 9'h133;
            8'h25: r = 9'h134;
            8'h2E: r = 9'h135;
            8'h36: r = 9'h136;
            8'h3D: r = 9'h137;
            8'h3E: r = 9'h138;
            8'h46: r = 9'h139;
            8'h29: r = 9'h120;
            8'h5A: r = 9'h10D;
            8'h66: r = 9'h108;
            default: r = 9'h000;
        endcase
        return r;
    endfunction
`endif

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: input synchronizers, ps2c glitch filter, 11-bit frame FSM
// and inter-bit timeout. Emits one byte_valid pulse per good frame.
module ps2_rx_frame
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          c_s1, c_s2, d_s1, d_s2;
    logic          c_filt, c_prev;
    logic [FW-1:0] f_cnt;
    logic          strobe;

    // Lines idle high, so the conditioning stages reset to 1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            c_filt <= 1'b1;
            c_prev <= 1'b1;
            f_cnt  <= '0;
        end else begin
            c_s1   <= ps2c;
            c_s2   <= c_s1;
            d_s1   <= ps2d;
            d_s2   <= d_s1;
            c_prev <= c_filt;
            if (c_s2 == c_filt) begin
                f_cnt <= '0;
            end else if (f_cnt == F_LAST) begin
                c_filt <= c_s2;
                f_cnt  <= '0;
            end else begin
                f_cnt <= f_cnt + 1'b1;
            end
        end
    end

    assign strobe = c_prev & ~c_filt;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] t_cnt;
    logic          timeout;
    logic          bv_n, err_n;

    assign timeout = (state != F_IDLE) && !strobe && (t_cnt == T_LAST);
    assign data    = shreg;

    always_comb begin
        state_n = state;
        bv_n    = 1'b0;
        err_n   = 1'b0;
        if (timeout) begin
            state_n = F_IDLE;
            err_n   = 1'b1;
        end else if (strobe) begin
            unique case (state)
                F_IDLE:   if (!d_s2) state_n = F_DATA;
                F_DATA:   if (bit_cnt == 3'd7) state_n = F_PARITY;
                F_PARITY: state_n = F_STOP;
                F_STOP: begin
                    state_n = F_IDLE;
                    if (d_s2 && (^{shreg, par_bit})) bv_n = 1'b1;
                    else err_n = 1'b1;
                end
                default:  state_n = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= F_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            t_cnt      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            byte_valid <= bv_n;
            frame_err  <= err_n;
            if (state == F_IDLE || strobe) t_cnt <= '0;
            else t_cnt <= t_cnt + 1'b1;
            if (state == F_IDLE) bit_cnt <= '0;
            if (strobe && state == F_DATA) begin
                shreg   <= {d_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (strobe && state == F_PARITY) par_bit <= d_s2;
        end
    end

endmodule

// File: rtl/kbd_input_controller.sv
// PS/2 keyboard to INPR/FGI bridge: make/break decoder, key FIFO, CPU handshake.
// Define KBD_ASCII_EN to push ASCII instead of raw set-2 scancodes.
module kbd_input_controller
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       inp_ack,
    output logic [7:0] inpr,
    output logic       fgi,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic       byte_valid;
    logic [7:0] data;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .clr        (clr),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .byte_valid (byte_valid),
        .data       (data),
        .frame_err  (frame_err)
    );

    dec_state_t dstate, dstate_n;
    logic [7:0] last_make;
    logic       latch_make;
    logic       push_hit;
    logic       push;
    logic [7:0] push_data;
`ifdef KBD_ASCII_EN
    logic       map_ok;
`endif

    always_comb begin
        dstate_n   = dstate;
        latch_make = 1'b0;
        push_hit   = 1'b0;
        if (byte_valid) begin
            unique case (dstate)
                D_MAKE: begin
                    if (data == BREAK_CODE) dstate_n = D_BREAK;
                    else if (data == EXT_CODE) dstate_n = D_EXT;
                    else if (data != 8'h00 && data != 8'hFF) latch_make = 1'b1;
                end
                D_BREAK: begin
                    dstate_n = D_MAKE;
                    push_hit = (data == last_make) && (last_make != 8'h00);
                end
                D_EXT: begin
                    if (data == BREAK_CODE) dstate_n = D_EXT_BREAK;
                    else dstate_n = D_MAKE;
                end
                D_EXT_BREAK: dstate_n = D_MAKE;
                default:     dstate_n = D_MAKE;
            endcase
        end
`ifdef KBD_ASCII_EN
        {map_ok, push_data} = scan_to_ascii(data);
        push = push_hit & map_ok;
`else
        push_data = data;
        push      = push_hit;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dstate    <= D_MAKE;
            last_make <= 8'h00;
        end else begin
            dstate <= dstate_n;
            if (latch_make) last_make <= data;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, empty, pop, wr;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = !fgi && !empty;
    // A full FIFO still takes a key when the same edge pops one.
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            inpr     <= 8'h00;
            fgi      <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr) overflow <= 1'b1;
            if (pop) begin
                inpr <= mem[rptr];
                fgi  <= 1'b1;
            end else if (inp_ack && fgi) begin
                fgi <= 1'b0;
            end
        end
    end

endmodule

// File: doc/kbd_input_controller.md
Name: kbd_input_controller

Overview:
- System-clock-domain controller between the PS/2 keyboard pins and the CPU input register (INPR) and input flag (FGI).
- Oversamples and filters ps2c, deframes 11-bit frames, and runs a make/break decoder that emits each key once, on release.
- Queues completed keys in a small FIFO and sequences the INPR/FGI handshake with the CPU's INP instruction.

Parameters:
- FIFO_DEPTH, 4, number of queued key codes; power of two, 2..16.
- FILTER_LEN, 8, consecutive equal clk samples required before the filtered ps2c changes.
- TIMEOUT_CYCLES, 50000, clk cycles without a bit strobe before a partial frame is aborted.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-high.
- ps2c  in  1  raw keyboard clock (asynchronous).
- ps2d  in  1  raw keyboard data (asynchronous).
- inp_ack  in  1  one-cycle pulse; the CPU executed INP and consumed INPR.
- inpr  out  8  key code presented to the CPU.
- fgi  out  1  high while inpr holds an unconsumed key.
- overflow  out  1  sticky; a key was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.

Behaviour:
- Reset values: inpr=8'h00, fgi=0, overflow=0, frame_err=0. FIFO is empty and all FSMs are in IDLE/MAKE. clr mid-frame discards the partial frame and any pending break/extended state.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchronizer.
  - Filtered ps2c toggles only after FILTER_LEN consecutive equal synchronized samples.
  - A bit strobe is a one-cycle pulse on each falling edge of filtered ps2c. ps2d is sampled in that same cycle.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: a strobe with ps2d=0 (start bit) enters DATA. A strobe with ps2d=1 stays in IDLE and raises no error.
  - DATA: 8 strobes, LSB first, then PARITY.
  - PARITY: the 8 data bits plus the parity bit must have odd parity.
  - STOP: ps2d must be 1. On success, byte_valid pulses for one cycle. On a parity or stop failure, frame_err pulses and the byte is discarded. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES clk cycles without a strobe returns the FSM to IDLE and pulses frame_err.
- Decoder FSM (MAKE, BREAK, EXT, EXT_BREAK), acting on each byte_valid:
  - MAKE:
    - 0xF0 goes to BREAK.
    - 0xE0 goes to EXT.
    - 0x00 and 0xFF are dropped.
    - Any other byte is latched into last_make. Typematic repeats simply re-latch it.
  - BREAK: if the byte equals last_make, push it to the FIFO; otherwise drop it. Return to MAKE.
  - EXT: 0xF0 goes to EXT_BREAK; any other byte returns to MAKE. Extended keys are never pushed.
  - EXT_BREAK: any byte returns to MAKE.
- FIFO:
  - A push while full drops the key and sets overflow; overflow clears only on clr.
  - A simultaneous push and pop is legal in any state except full-and-no-pop.
- CPU handshake:
  - When fgi=0 and the FIFO is non-empty, pop to inpr and set fgi=1 on the same edge.
  - inp_ack with fgi=1 clears fgi on the next edge. inp_ack with fgi=0 is ignored.
  - After a clear, fgi stays low for at least one full cycle before the next load.
  - inpr holds its value until the next load.
- Latency: with the FIFO empty and fgi=0, fgi rises exactly 3 clk cycles after the stop-bit strobe of the break byte. The stages are byte_valid, push, load.

Optional Feature:
- Macro KBD_ASCII_EN.
- Defined: the pushed value is the ASCII translation of the scancode:
  - A–Z give uppercase 0x41–0x5A.
  - 0–9 give 0x30–0x39.
  - Space gives 0x20, Enter gives 0x0D, Backspace gives 0x08.
  - Unmapped codes are dropped and not pushed.
- Undefined: the raw set-2 scancode is pushed and no table is synthesized.

Decomposition:
- Package kbd_pkg:
  - Constants for BREAK_CODE 0xF0 and EXT_CODE 0xE0.
  - Frame and decoder state enums.
  - A scancode-to-ASCII function under KBD_ASCII_EN.
- One sub-module, ps2_rx_frame: synchronizer, filter, frame FSM and timeout. Outputs byte_valid, byte and frame_err.
- The decoder, FIFO and handshake stay in the top module.

Test Plan:
1. Frames 0x1C, 0xF0, 0x1C (key A) → one push; fgi=1 with inpr=0x1C (0x41 with KBD_ASCII_EN) exactly 3 cycles after the last stop strobe.
2. Frames 0x1C ×5, then 0xF0, 0x1C → exactly one key queued; after inp_ack, fgi=0 and stays 0.
3. A frame with a bad parity bit, then a frame with stop=0 → frame_err pulses twice, nothing queued, next valid A/release is accepted.
4. 6 key releases with no inp_ack and FIFO_DEPTH=4 → inpr=first key, 4 queued, 1 dropped, overflow=1; 4 inp_ack pulses drain the keys in order.
5. ps2c stops after 5 bits (bench uses TIMEOUT_CYCLES=200) → frame_err pulse at cycle 200; the next full frame decodes correctly.
6. A glitch on ps2c shorter than FILTER_LEN → no strobe; clr asserted mid-frame → all outputs at reset values, FSMs idle.
